// File: rtl/mul_operand_sequencer.sv
// Issue stage for the shift-add multiplier: operand FIFO, start/done sequencing, result hold.
// Optional macro MUL_SEQ_ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier.
module mul_operand_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_multiplier,
    input  logic [WIDTH-1:0]         in_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic                     mul_start,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic [CNT_W-1:0]         job_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [PtrW-1:0]    r_wr_ptr;
    logic [PtrW-1:0]    r_rd_ptr;
    logic [CntW-1:0]    r_count;

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [2*WIDTH-1:0] r_product;
    logic [CNT_W-1:0]   r_jobs;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_capture;
    logic               w_zero;

    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_zero      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: w_state_nxt = StWait;
            StWait: begin
                if (mul_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = StIssue;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        // A zero operand gives a zero product; present it directly without a start pulse.
        if (w_pop && ((r_mem_a[r_rd_ptr] == '0) || (r_mem_b[r_rd_ptr] == '0))) begin
            w_zero      = 1'b1;
            w_state_nxt = StHold;
        end
`endif
    end

    // FIFO storage needs no reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_multiplier;
            r_mem_b[r_wr_ptr] <= in_multiplicand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_product <= '0;
            r_jobs    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_op_a   <= r_mem_a[r_rd_ptr];
                r_op_b   <= r_mem_b[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_capture) begin
                r_product <= mul_product;
                r_jobs    <= r_jobs + 1'b1;
            end else if (w_zero) begin
                r_product <= '0;
                r_jobs    <= r_jobs + 1'b1;
            end
        end
    end

    assign in_ready         = (r_count != FullCnt);
    assign fifo_count       = r_count;
    assign mul_multiplier   = r_op_a;
    assign mul_multiplicand = r_op_b;
    assign mul_start        = (r_state == StIssue);
    assign out_valid        = (r_state == StHold);
    assign out_product      = r_product;
    assign busy             = (r_state != StIdle) || !w_empty;
    assign job_count        = r_jobs;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: behavioural multiplier model plus a product queue scoreboard.
module tb_mul_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mul_multiplier;
    logic [31:0] mul_multiplicand;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_product;
    logic [2:0]  fifo_count;
    logic        busy;
    logic [15:0] job_count;

    logic        model_done = 1'b0;
    logic        spur_done  = 1'b0;
    logic        mdl_busy   = 1'b0;
    int          mdl_cnt    = 0;
    int          mdl_lat    = 33;
    logic [31:0] mdl_a      = '0;
    logic [31:0] mdl_b      = '0;
    logic [63:0] mdl_prod   = '0;

    int          n_cmp      = 0;
    int          n_err      = 0;
    int          n_start    = 0;
    int          n_results  = 0;
    logic        last_push  = 1'b0;
    logic        last_hs_ne = 1'b0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    assign mul_done    = model_done | spur_done;
    assign mul_product = mdl_prod;

    mul_operand_sequencer #(
        .WIDTH (32),
        .DEPTH (4),
        .CNT_W (16)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplier    (in_a),
        .in_multiplicand  (in_b),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_start        (mul_start),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .fifo_count       (fifo_count),
        .busy             (busy),
        .job_count        (job_count)
    );

    // Multiplier model: not reset, so a job cut off by reset still raises a stale done.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                model_done <= 1'b1;
                mdl_prod   <= 64'(mdl_a) * 64'(mdl_b);
                mdl_busy   <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (mul_start === 1'b1) begin
            mdl_busy <= 1'b1;
            mdl_a    <= mul_multiplier;
            mdl_b    <= mul_multiplicand;
            mdl_cnt  <= mdl_lat - 1;
        end
    end

    always @(negedge clk) if (mul_start === 1'b1) n_start++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, then account for the handshakes the next posedge will take.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        #1;
        last_push = in_valid && in_ready;
        if (last_push) exp_q.push_back(64'(a) * 64'(b));
        if (out_valid && out_ready) begin
            chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("out_product", out_product, exp_q.pop_front());
            n_results++;
            last_hs_ne = (fifo_count != 0);
        end
    endtask

    task automatic drain(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles && (exp_q.size() != 0 || out_valid); i++) step(0, 0, 0, 1);
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) step(0, 0, 0, 0);
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int s0;
        int jobs_base;
        int sent;
        logic pend;
        logic saw_valid;
        logic [31:0] ra;
        logic [31:0] rb;

        // Asynchronous reset, checked before any clock edge.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single job 5x5 with a 33-cycle multiplier.
        mdl_lat = 33;
        s0 = n_start;
        step(1, 5, 5, 0);
        step(0, 0, 0, 0);
        chk("lat_no_start_yet", 64'(mul_start), 64'd0);
        step(0, 0, 0, 0);
        chk("lat_start", 64'(mul_start), 64'd1);
        chk("lat_operand_a", 64'(mul_multiplier), 64'd5);
        step(0, 0, 0, 0);
        chk("start_one_cycle", 64'(mul_start), 64'd0);
        chk("operand_stable", 64'(mul_multiplicand), 64'd5);
        wait_valid(80);
        chk("single_product", out_product, 64'd25);
        chk("single_jobs", 64'(job_count), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_product", out_product, 64'd25);
        drain(10);
        chk("single_one_start", 64'(n_start - s0), 64'd1);
        chk("single_idle", 64'(busy), 64'd0);

        // Width extremes.
        mdl_lat = 5;
        step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_valid(40);
        chk("max_product", out_product, 64'hFFFF_FFFE_0000_0001);
        drain(10);

        // Spurious done in IDLE, then during ISSUE.
        s0 = int'(job_count);
        step(0, 0, 0, 1);
        spur_done = 1'b1;
        step(0, 0, 0, 1);
        spur_done = 1'b0;
        step(0, 0, 0, 1);
        chk("spur_idle_valid", 64'(out_valid), 64'd0);
        chk("spur_idle_jobs", 64'(job_count), 64'(s0));
        mdl_lat = 6;
        step(1, 3, 4, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("spur_in_issue", 64'(mul_start), 64'd1);
        spur_done = 1'b1;
        step(0, 0, 0, 1);
        spur_done = 1'b0;
        chk("spur_issue_valid", 64'(out_valid), 64'd0);
        chk("spur_issue_jobs", 64'(job_count), 64'(s0));
        drain(40);
        chk("spur_jobs_after", 64'(job_count), 64'(s0 + 1));

        // Backpressure: five pairs with the output stalled.
        mdl_lat = 3;
        for (int i = 1; i <= 5; i++) step(1, 32'(i), 3, 0);
        wait_valid(40);
        step(0, 0, 0, 0);
        chk("bp_fifo_full", 64'(fifo_count), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step(1, 9, 9, 0);
        chk("bp_no_push_when_full", 64'(last_push), 64'd0);
        pend = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            s0 = n_results;
            step(0, 0, 0, 1);
            if (pend) begin
                chk("b2b_start", 64'(mul_start), 64'd1);
                pend = 1'b0;
            end
            if (n_results != s0 && last_hs_ne) pend = 1'b1;
        end
        drain(20);

        // Zero operand pair.
        mdl_lat = 4;
        s0 = n_start;
        step(1, 0, 7, 0);
        wait_valid(30);
        chk("zero_product", out_product, 64'd0);
        drain(10);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        chk("zero_start_pulses", 64'(n_start - s0), 64'd0);
`else
        chk("zero_start_pulses", 64'(n_start - s0), 64'd1);
`endif

        // Reset in the middle of WAIT.
        mdl_lat = 20;
        step(1, 6, 7, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_fifo", 64'(fifo_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_jobs", 64'(job_count), 64'd0);
        chk("mid_rst_mul_a", 64'(mul_multiplier), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        jobs_base = n_results;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 1);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("stale_done_no_result", 64'(saw_valid), 64'd0);
        chk("stale_done_jobs", 64'(job_count), 64'd0);

        // Randomised traffic.
        sent = 0;
        for (int i = 0; i < 4000 && sent < 40; i++) begin
            ra = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            rb = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            mdl_lat = int'($urandom_range(1, 12));
            step(logic'($urandom_range(1)), ra, rb, logic'($urandom_range(3) != 0));
            if (last_push) sent++;
        end
        chk("rand_all_sent", 64'(sent), 64'd40);
        drain(1500);
        chk("rand_job_count", 64'(job_count), 64'(n_results - jobs_base));
        chk("rand_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream issue stage for the 32-bit shift-add multiplier.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues each pair to the multiplier with a one-cycle start pulse, then waits for the multiplier's done.
- Captures the full-width product and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept (not full).
- in_multiplier  input  WIDTH  operand A.
- in_multiplicand  input  WIDTH  operand B.
- mul_multiplier  output  WIDTH  operand A to the multiplier.
- mul_multiplicand  output  WIDTH  operand B to the multiplier.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_done  input  1  multiplier result valid.
- mul_product  input  2*WIDTH  multiplier result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_product  output  2*WIDTH  captured product.
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  state is not IDLE, or the FIFO is non-empty.
- job_count  output  CNT_W  completed results; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count cleared; state IDLE; outputs reset to 0, except in_ready=1 and fifo_count=0.
  - An in-flight job is discarded.
  - Reset deasserted mid-job: the first mul_done seen in IDLE is ignored.
- FIFO:
  - Push on in_valid&&in_ready.
  - in_ready = (count != DEPTH); there is no bypass path when full.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - Order is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO is non-empty, pop the head into the operand registers and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle, then go to WAIT. mul_done is ignored in ISSUE.
  - WAIT: on mul_done=1, load mul_product into out_product, set out_valid=1, increment job_count, go to HOLD. No timeout.
  - HOLD: out_valid=1 and out_product is stable until out_ready=1. On the handshake edge:
    - FIFO non-empty: pop the next pair and go to ISSUE (back-to-back).
    - Otherwise: go to IDLE.
- mul_multiplier and mul_multiplicand are held stable from ISSUE through the end of WAIT.
- mul_done outside WAIT is ignored.
- Latency: pair accepted at edge E into an empty FIFO while IDLE → operands loaded at E+1 → mul_start high between edges E+1 and E+2.
- out_product is the multiplier's product passed through unmodified; no truncation.

Optional Feature:
- Macro MUL_SEQ_ZERO_BYPASS_EN.
- When defined, in IDLE/HOLD a popped pair with either operand == 0 skips ISSUE/WAIT:
  - next state HOLD; out_product=0; out_valid=1 one edge after the pop; job_count increments; mul_start is never pulsed.
- When undefined, every pair goes through the multiplier.

Test Plan:
- Single job: A=5, B=5, multiplier model with done 33 cycles after start → one mul_start pulse; out_product=25; out_valid held until out_ready; job_count=1.
- Width extremes: A=B=32'hFFFFFFFF → out_product=64'hFFFFFFFE00000001, with no truncation of the full 2*WIDTH product.
- Backpressure: push 5 pairs (1..5)×3 with out_ready=0 → in_ready falls after the FIFO holds 4 while the first job is in HOLD; release out_ready → results 3, 6, 9, 12, 15 in order, issued back-to-back with no IDLE cycle.
- Spurious done: mul_done pulsed in IDLE and during ISSUE → no out_valid; no job_count change.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs at reset values immediately; FIFO empty; a stale mul_done afterwards produces no result.
- With MUL_SEQ_ZERO_BYPASS_EN: pair (0, 7) → out_product=0 with mul_start never asserted. Without the macro, the same pair pulses mul_start and returns 0.
